// File: rtl/irq_pkg.sv
// Shared constants, state encoding and helpers for the 8x3 interrupt-request encoder.
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // All-ones so that request lines already high when reset releases raise no event.
    localparam logic [N_REQ-1:0] REQ_Q_RST = 8'hFF;

    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational 8-to-3 priority encoder; the lowest set bit wins.
module prio_enc_8x3
    import irq_pkg::*;
(
    input  logic [N_REQ-1:0] pending,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scanning downward lets the last hit, the lowest index, take priority.
    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/irq_encoder_8x3.sv
// Edge-detecting interrupt request collector that presents the highest-priority
// pending request as a 3-bit index over a valid/ack handshake.
module irq_encoder_8x3
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic [N_REQ-1:0] REQ,
    input  logic             IRQ_ACK,
    output logic             IRQ_VALID,
    output logic [IDX_W-1:0] IRQ_IDX,
    output logic [N_REQ-1:0] PENDING,
    output logic             OVF
);

    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] req_edge;
    logic [N_REQ-1:0] clr;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    state_t           state;

    prio_enc_8x3 u_prio_enc (
        .pending (pending),
        .idx     (enc_idx),
        .any     (enc_any)
    );

    // Only an acknowledged presentation clears its own bit.
    always_comb begin
        req_edge = REQ & ~req_q;
        clr      = '0;
        if (state == ST_PRESENT && IRQ_ACK) begin
            clr = idx_onehot(IRQ_IDX);
        end
    end

    // Set wins over clear, so an event landing on the bit being acknowledged survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= REQ_Q_RST;
            pending <= '0;
            OVF     <= 1'b0;
        end else begin
            req_q   <= REQ;
            pending <= (pending & ~clr) | req_edge;
            OVF     <= |(req_edge & pending & ~clr);
        end
    end

    // A presentation is held until acknowledged: no retraction, no pre-emption.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            IRQ_VALID <= 1'b0;
            IRQ_IDX   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (EN && enc_any) begin
                        IRQ_IDX   <= enc_idx;
                        IRQ_VALID <= 1'b1;
                        state     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (IRQ_ACK) begin
                        IRQ_VALID <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    IRQ_VALID <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign PENDING = pending;

endmodule
